// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA output path.
// It runs one horizontal/vertical counter chain in the pix_clk domain. The chain
// advances by one pixel on each pix_en cycle. The position flags (active, hsync,
// vsync) are decoded from the next-state counts and then registered. As a result
// they always line up with the hcount/vcount visible in the same cycle. The
// strobes mark the first cycle that a new position is shown.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10
) (
  input  logic          pix_clk,
  input  logic          reset_n,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  // Every boundary value is strictly below its total, so each one fits in CW bits.
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG_C = CW'(HS_BEG);
  localparam logic [CW-1:0] HS_END_C = CW'(HS_END);
  localparam logic [CW-1:0] VS_BEG_C = CW'(VS_BEG);
  localparam logic [CW-1:0] VS_END_C = CW'(VS_END);

  // Parameter sanity checks, evaluated at elaboration.
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_size_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_chk
    $error("vga_timing_gen: every timing parameter must be >= 1");
  end

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_wrap;
  logic          active_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          line_nxt;
  logic          frame_nxt;
  logic          vblank_nxt;

  // Next raster position: step one pixel on pix_en; the line counter moves only on a horizontal wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    h_nxt  = hcount;
    v_nxt  = vcount;
    h_wrap = (hcount == H_LAST);
    if (pix_en) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? '0 : vcount + CW'(1);
      end else begin
        h_nxt = hcount + CW'(1);
      end
    end
  end

  // Decode flags and strobes from the next position so they register alongside the counts.
  always_comb begin
    active_nxt = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
    hsync_nxt  = ((h_nxt >= HS_BEG_C) && (h_nxt < HS_END_C)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_nxt  = ((v_nxt >= VS_BEG_C) && (v_nxt < VS_END_C)) ? VSYNC_POL : ~VSYNC_POL;
    line_nxt   = pix_en && (h_nxt == '0);
    frame_nxt  = line_nxt && (v_nxt == '0);
    vblank_nxt = line_nxt && (v_nxt == V_ACT_C);
  end

  // Output registers. Reset parks the raster on the last pixel so the first pix_en lands on (0,0).
  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount       <= H_LAST;
      vcount       <= V_LAST;
      active       <= 1'b0;
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values, as real flops do.
      hcount       <= h_nxt;
      vcount       <= v_nxt;
      active       <= active_nxt;
      hsync        <= hsync_nxt;
      vsync        <= vsync_nxt;
      line_start   <= line_nxt;
      frame_start  <= frame_nxt;
      vblank_start <= vblank_nxt;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator for the VGA output path. It produces pixel/line coordinates, an active-video flag, sync pulses of configurable polarity, and single-cycle line/frame/vblank strobes for the framebuffer reader and pixel pipeline. A single counter chain in the pix_clk domain is gated by a pixel enable, so the same block serves 640x480 and other modes from one fast clock. All outputs are registered.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync (0 = active-low)
CW, 10, width of hcount/vcount

Ports:
pix_clk  in  1  pixel/system clock, rising edge
reset_n  in  1  asynchronous active-low reset
pix_en  in  1  advance raster by one pixel this cycle
hcount  out  CW  current pixel column, 0..H_TOTAL-1
vcount  out  CW  current line, 0..V_TOTAL-1
active  out  1  1 when hcount < H_ACTIVE and vcount < V_ACTIVE
hsync  out  1  horizontal sync, level per HSYNC_POL
vsync  out  1  vertical sync, level per VSYNC_POL
line_start  out  1  one-cycle pulse on arrival at hcount=0
frame_start  out  1  one-cycle pulse on arrival at (0,0)
vblank_start  out  1  one-cycle pulse on arrival at (0,V_ACTIVE)

Behaviour:
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525 default).
- Elaboration check (simulation $error): H_TOTAL and V_TOTAL each <= 2**CW; every timing parameter >= 1.
- Reset (async assert, sync release): hcount=H_TOTAL-1, vcount=V_TOTAL-1, active=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, all strobes 0.
- Advance on pix_clk edge with pix_en=1: hcount+1, wrapping H_TOTAL-1 -> 0. vcount advances only in the same cycle that hcount wraps (single clock domain, no derived clocks); V_TOTAL-1 -> 0.
- pix_en=0: hcount, vcount, active, hsync, vsync hold; all strobes driven 0 that cycle.
- Flags are decoded from next-state counts and registered, so active/hsync/vsync always correspond to the hcount/vcount visible in the same cycle (zero relative latency).
- hsync asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751 default), independent of vcount.
- vsync asserted iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491 default), full lines, changing at hcount=0.
- Strobes: high for exactly one pix_clk cycle, on the cycle the new position first appears; never repeated while pix_en is low.
- First pix_en after reset: outputs (0,0), active=1, line_start=1, frame_start=1 together.
- Simultaneous wraps: at (H_TOTAL-1,V_TOTAL-1) -> (0,0), line_start and frame_start both assert; vblank_start coincides with line_start only.
- Reset mid-frame: outputs return to reset values immediately; no strobe is emitted until the next pix_en.

Test Plan:
- Reset, pix_en=1 constant, defaults -> first cycle (0,0) with line_start=frame_start=active=1; frame_start period 420000 cycles, line_start period 800.
- Defaults, one line -> hsync=0 for hcount 656..751 (96 cycles), 1 elsewhere; active=0 for hcount 640..799.
- Defaults, one frame -> vsync=0 on lines 490..491 only (1600 cycles); vblank_start once at (0,480); active=0 for vcount >= 480.
- pix_en toggling 1,0 (div-by-2) -> counts advance every other cycle, frame_start period 840000 cycles, each strobe exactly 1 cycle wide.
- Params H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1, HSYNC_POL=VSYNC_POL=1 -> H_TOTAL=8, V_TOTAL=6; hsync=1 at hcount 5..6; vsync=1 on line 4; frame period 48 cycles.
- Assert reset_n=0 at (300,200) asynchronously (mid-cycle) -> outputs go to (799,524), active=0, syncs inactive without waiting for a clock edge; after release, the next pix_en gives (0,0) with frame_start.
